// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample packer.
//   - state_e    : packer FSM states (StIdle, StFill)
//   - Def*       : default geometry (14-bit samples, 16-bit lanes, 4 lanes)
//   - lane_fill(): widens one sample into its lane slot (sign-extend or zero-pad)
package adc_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StFill = 1'b1
  } state_e;

  localparam int unsigned DefSampleW = 14;
  localparam int unsigned DefLaneW   = 16;
  localparam int unsigned DefLanes   = 4;

  // Widest lane lane_fill() can produce; callers slice the low LANE_W bits.
  localparam int unsigned MaxLaneW = 64;

  // Bits at or above sample_w become copies of the sample MSB when sign_ext is
  // set, zeros otherwise. The sample arrives zero-extended to MaxLaneW.
  function automatic logic [MaxLaneW-1:0] lane_fill(input logic [MaxLaneW-1:0] sample,
                                                    input int unsigned         sample_w,
                                                    input logic                sign_ext);
    logic [MaxLaneW-1:0] keep_mask;
    logic                msb;
    keep_mask = ~({MaxLaneW{1'b1}} << sample_w);
    msb       = sign_ext & (|(sample & (MaxLaneW'(1) << (sample_w - 1))));
    return (sample & keep_mask) | ({MaxLaneW{msb}} & ~keep_mask);
  endfunction

endpackage

// File: rtl/adc_ramp_gen.sv
// Free-running test ramp for the ADC sample packer.
// Ports:
//   clk     - sample clock (rising edge)
//   nreset  - asynchronous active-low reset; ramp returns to 0
//   advance - step the ramp by one this cycle
//   ramp    - current SAMPLE_W-bit ramp value, wraps 2^SAMPLE_W-1 -> 0
module adc_ramp_gen
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DefSampleW
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                advance,
  output logic [SAMPLE_W-1:0] ramp
);

  logic [SAMPLE_W-1:0] ramp_q, ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (advance) begin
      ramp_d = ramp_q + SAMPLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign ramp = ramp_q;

endmodule

// File: rtl/adc_sample_packer.sv
// ADC capture front-end: packs LANES consecutive SAMPLE_W-bit samples into one
// LANE_W-per-lane output word (first sample in lane 0) and offers it on a
// valid/ready handshake. Completed words that cannot be handed over because a
// word is still held are dropped and counted (saturating).
//
// Optional build macro ADC_PACK_TESTGEN_EN: adds an internal ramp source that
// replaces i_sample/i_sample_valid while i_testgen_sel=1.
//
// Ports:
//   i_62clk         sample clock, rising edge
//   i_nreset        asynchronous active-low reset
//   i_enable        capture enable; low discards the partial word, FSM to IDLE
//   i_sign_ext      1: sign-extend each sample into its lane, 0: zero-pad
//   i_sample        ADC sample
//   i_sample_valid  i_sample valid this cycle
//   i_testgen_sel   pick the internal ramp (only with ADC_PACK_TESTGEN_EN)
//   i_ready         downstream takes o_data this cycle
//   i_cnt_clr       synchronous clear of o_overflow_cnt
//   o_data          packed word
//   o_valid         o_data holds an unconsumed word
//   o_overflow_cnt  completed words dropped, saturating
//   o_busy          FSM is in FILL
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned LANE_W   = DefLaneW,
  parameter int unsigned LANES    = DefLanes,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned OUT_W   = LANE_W * LANES
) (
  input  logic                i_62clk,
  input  logic                i_nreset,
  input  logic                i_enable,
  input  logic                i_sign_ext,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  input  logic                i_testgen_sel,
  input  logic                i_ready,
  input  logic                i_cnt_clr,
  output logic [OUT_W-1:0]    o_data,
  output logic                o_valid,
  output logic [CNT_W-1:0]    o_overflow_cnt,
  output logic                o_busy
);

  localparam int unsigned     IdxW    = $clog2(LANES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [IdxW-1:0]     lane_idx_q, lane_idx_d;
  logic [OUT_W-1:0]    pack_q, pack_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SAMPLE_W-1:0] src_sample;
  logic                src_valid;
  logic                accept;
  logic                word_done;
  logic                xfer;
  logic                load;
  logic                drop;
  logic [MaxLaneW-1:0] fill_wide;
  logic [LANE_W-1:0]   lane_val;

  // Sample source selection
`ifdef ADC_PACK_TESTGEN_EN
  logic [SAMPLE_W-1:0] ramp;

  // Ramp only steps on samples it actually supplied.
  adc_ramp_gen #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ramp_gen (
    .clk     (i_62clk),
    .nreset  (i_nreset),
    .advance (accept & i_testgen_sel),
    .ramp    (ramp)
  );

  assign src_sample = i_testgen_sel ? ramp : i_sample;
  assign src_valid  = i_testgen_sel ? 1'b1 : i_sample_valid;
`else
  logic unused_testgen_sel;
  assign unused_testgen_sel = i_testgen_sel;

  assign src_sample = i_sample;
  assign src_valid  = i_sample_valid;
`endif

  // Lane widening
  assign fill_wide = lane_fill(MaxLaneW'(src_sample), SAMPLE_W, i_sign_ext);
  assign lane_val  = fill_wide[LANE_W-1:0];

  if (LANE_W < MaxLaneW) begin : g_fill_hi
    logic unused_fill_hi;
    assign unused_fill_hi = ^fill_wide[MaxLaneW-1:LANE_W];
  end

  // Handshake / completion decode
  assign accept    = (state_q == StFill) && i_enable && src_valid;
  assign word_done = accept && (lane_idx_q == LastIdx);
  assign xfer      = valid_q && i_ready;
  // A finished word may load if the output slot is empty or empties this cycle.
  assign load      = word_done && (!valid_q || i_ready);
  assign drop      = word_done && valid_q && !i_ready;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    pack_d     = pack_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (!i_enable) begin
          state_d    = StIdle;
          lane_idx_d = '0;
          pack_d     = '0;
        end else if (accept) begin
          pack_d[lane_idx_q*LANE_W +: LANE_W] = lane_val;
          lane_idx_d = (lane_idx_q == LastIdx) ? '0 : lane_idx_q + IdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // pack_d already holds the final lane, so it is the complete word.
    if (load) begin
      data_d  = pack_d;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // Clear wins over a coincident increment.
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (drop && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q    <= StIdle;
      lane_idx_q <= '0;
      pack_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      pack_q     <= pack_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_overflow_cnt = cnt_q;
  assign o_busy         = (state_q == StFill);

endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench for adc_sample_packer (default build, 14/16/4 geometry,
// 4-bit overflow counter so saturation is reachable quickly).
module tb_adc_sample_packer;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic        clk;
  logic        nreset;
  logic        enable;
  logic        sign_ext;
  logic [13:0] sample;
  logic        svalid;
  logic        tsel;
  logic        ready;
  logic        clr;
  logic [63:0] data;
  logic        valid;
  logic [CntW-1:0] cnt;
  logic        busy;

  int n_tests;
  int n_fail;

  // Reference state: lanes gathered so far, held output word, drop count.
  bit          m_fill;
  logic [15:0] m_lanes[$];
  logic [63:0] m_data;
  bit          m_valid;
  int          m_cnt;

  adc_sample_packer #(
    .SAMPLE_W (14),
    .LANE_W   (16),
    .LANES    (4),
    .CNT_W    (CntW)
  ) dut (
    .i_62clk        (clk),
    .i_nreset       (nreset),
    .i_enable       (enable),
    .i_sign_ext     (sign_ext),
    .i_sample       (sample),
    .i_sample_valid (svalid),
    .i_testgen_sel  (tsel),
    .i_ready        (ready),
    .i_cnt_clr      (clr),
    .o_data         (data),
    .o_valid        (valid),
    .o_overflow_cnt (cnt),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [13:0] s, input logic se);
    int v;
    v = int'(s);
    if (se && v >= 8192) v += 49152;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_fill = 0;
    m_lanes.delete();
    m_data = '0;
    m_valid = 0;
    m_cnt = 0;
  endtask

  // Applies the current input values to the reference for one clock edge.
  task automatic model_step();
    bit xfer, load, drop;
    logic [63:0] w;
    xfer = m_valid && ready;
    load = 0;
    drop = 0;
    if (!m_fill) begin
      if (enable) m_fill = 1;
      m_lanes.delete();
    end else if (!enable) begin
      m_fill = 0;
      m_lanes.delete();
    end else if (svalid) begin
      m_lanes.push_back(lane_of(sample, sign_ext));
      if (m_lanes.size() == 4) begin
        w = '0;
        for (int k = 0; k < 4; k++) w = w + (64'(m_lanes[k]) << (16 * k));
        m_lanes.delete();
        if (!m_valid || ready) begin
          m_data = w;
          load = 1;
        end else begin
          drop = 1;
        end
      end
    end
    if (load) m_valid = 1;
    else if (xfer) m_valid = 0;
    if (clr) m_cnt = 0;
    else if (drop && m_cnt < CntMax) m_cnt++;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 64'(valid), 64'(m_valid));
    chk({tag, ".data"}, data, m_data);
    chk({tag, ".cnt"}, 64'(cnt), 64'(m_cnt));
    chk({tag, ".busy"}, 64'(busy), 64'(m_fill));
  endtask

  task automatic put(input string tag, input logic [13:0] s);
    svalid = 1;
    sample = s;
    tick(tag);
    svalid = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data0"}, data, 64'h0);
    chk({tag, ".valid0"}, 64'(valid), 64'h0);
    chk({tag, ".cnt0"}, 64'(cnt), 64'h0);
    chk({tag, ".busy0"}, 64'(busy), 64'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk = 0; nreset = 0; enable = 0; sign_ext = 0; sample = '0;
    svalid = 0; tsel = 0; ready = 1; clr = 0;
    model_reset();
    #1;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    nreset = 1;

    // Basic packing, first sample in lane 0
    enable = 1;
    tick("enter_fill");
    put("basic0", 14'h0001);
    put("basic1", 14'h0002);
    put("basic2", 14'h0003);
    put("basic3", 14'h0004);
    chk("basic_word", data, 64'h0004_0003_0002_0001);
    chk("basic_valid", 64'(valid), 64'h1);
    tick("basic_drain");
    chk("basic_valid_1cyc", 64'(valid), 64'h0);

    // Sign extension vs zero pad
    sign_ext = 1;
    put("sx0", 14'h2000); put("sx1", 14'h1FFF); put("sx2", 14'h3FFF); put("sx3", 14'h0000);
    chk("sign_ext_word", data, 64'h0000_FFFF_1FFF_E000);
    sign_ext = 0;
    put("zp0", 14'h2000); put("zp1", 14'h1FFF); put("zp2", 14'h3FFF); put("zp3", 14'h0000);
    chk("zero_pad_word", data, 64'h0000_3FFF_1FFF_2000);
    tick("zp_drain");

    // Back-pressure: first word held, two dropped
    ready = 0;
    for (int i = 0; i < 12; i++) put("bp", 14'(16'h100 + i));
    chk("bp_held_word", data, 64'h0103_0102_0101_0100);
    chk("bp_overflow", 64'(cnt), 64'd2);
    ready = 1;
    tick("bp_release");
    chk("bp_valid_clear", 64'(valid), 64'h0);
    clr = 1;
    tick("cnt_clr");
    clr = 0;
    chk("cnt_cleared", 64'(cnt), 64'h0);

    // Completion in the same cycle as a transfer
    ready = 0;
    for (int i = 0; i < 4; i++) put("ov_a", 14'(16'h21 + i));
    for (int i = 0; i < 3; i++) put("ov_b", 14'(16'h31 + i));
    ready = 1;
    put("ov_b3", 14'h34);
    chk("overlap_valid", 64'(valid), 64'h1);
    chk("overlap_word", data, 64'h0034_0033_0032_0031);
    chk("overlap_no_drop", 64'(cnt), 64'h0);
    tick("ov_drain");

    // Enable drop discards the partial word; IDLE ignores valids
    put("en_p0", 14'h5);
    put("en_p1", 14'h6);
    enable = 0;
    put("en_off", 14'h77);
    enable = 1;
    put("en_idle", 14'h78);
    put("en0", 14'hA); put("en1", 14'hB); put("en2", 14'hC); put("en3", 14'hD);
    chk("reenable_word", data, 64'h000D_000C_000B_000A);

    // Saturation, then clear coinciding with an increment
    ready = 0;
    for (int i = 0; i < 68; i++) put("sat", 14'(i));
    chk("sat_cnt", 64'(cnt), 64'(CntMax));
    chk("sat_held_word", data, 64'h000D_000C_000B_000A);
    clr = 1;
    tick("sat_clr");
    clr = 0;
    for (int i = 0; i < 3; i++) put("clrinc", 14'(i));
    clr = 1;
    put("clrinc3", 14'h3);
    clr = 0;
    chk("clr_wins", 64'(cnt), 64'h0);

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 19) != 0);
      ready    = 1'($urandom_range(0, 1));
      svalid   = ($urandom_range(0, 3) != 0);
      sign_ext = 1'($urandom_range(0, 1));
      tsel     = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 31) == 0);
      sample   = 14'($urandom());
      tick("rand");
    end
    svalid = 0; clr = 0; tsel = 0; enable = 1; ready = 0;

    // Asynchronous reset mid-word
    tick("pre_rst");
    put("rst_p0", 14'h11);
    put("rst_p1", 14'h12);
    nreset = 0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    #2;
    nreset = 1;
    ready = 1;
    tick("post_rst_enter");
    put("pr0", 14'h1); put("pr1", 14'h2); put("pr2", 14'h3); put("pr3", 14'h4);
    chk("post_reset_word", data, 64'h0004_0003_0002_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
